// File: rtl/lcd_st_timing_adapter_rl.sv
// lcd_st_timing_adapter_rl
// ------------------------------------------------------------------------
// Avalon-ST ready-latency adapter for the display datapath. It connects an
// upstream with input ready latency IN_RL to a downstream with output ready
// latency OUT_RL. Each beat is stored as {data, sop, eop} in a circular
// show-ahead buffer of DEPTH entries. in_ready is a credit: it is granted
// only while the buffer still has room for every beat that can be in flight.
//
// Parameters: DATA_W (beat width), IN_RL (0..4), OUT_RL (0..4),
//             DEPTH (buffer entries, must be >= IN_RL+1; use >= IN_RL+2 for
//             full throughput).
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_ready                     registered grant to the upstream
//   in_valid/in_data/in_startofpacket/in_endofpacket    upstream beat
//   out_ready                    downstream ready
//   out_valid/out_data/out_startofpacket/out_endofpacket downstream beat
//   fill_level                   registered buffer occupancy
//   protocol_err                 sticky protocol error (optional)
//
// Optional feature: define LCD_ST_TA_PROTOCOL_CHECK_EN to add protocol_err.
// With the check enabled, illegal upstream beats are dropped and flagged.
// Without it, illegal upstream beats are undefined behaviour.
// ------------------------------------------------------------------------
module lcd_st_timing_adapter_rl #(
    parameter int DATA_W = 8,
    parameter int IN_RL  = 1,
    parameter int OUT_RL = 0,
    parameter int DEPTH  = 4,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              in_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [FW-1:0]     fill_level
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
    ,
    output logic              protocol_err
`endif
);

    localparam int W  = DATA_W + 2;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (DEPTH < IN_RL + 1) begin : g_bad_depth
        $error("lcd_st_timing_adapter_rl: DEPTH must be at least IN_RL+1");
    end

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [FW-1:0]   fill, fill_next;
    logic            empty, wr_en, pop, out_slot;
    logic [W-1:0]    head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (fill == '0);

    // ---------------- output-side ready history ----------------
    // out_slot says whether a beat may be shown this cycle: with OUT_RL=0
    // it is always allowed (handshake), otherwise it follows out_ready
    // from OUT_RL cycles ago.
    if (OUT_RL == 0) begin : g_out_rl0
        assign out_slot = 1'b1;
    end else begin : g_out_rl
        logic [OUT_RL-1:0] hist;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) hist <= '0;
            else          hist <= OUT_RL'({hist, out_ready});
        end
        assign out_slot = hist[OUT_RL-1];
    end

    assign out_valid = out_slot && !empty;
    // With OUT_RL>0 the downstream is obliged to take every valid beat.
    assign pop       = out_valid && ((OUT_RL > 0) || out_ready);

    // ---------------- write acceptance ----------------
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
    logic full, in_ok, bad_in, bad_out;
    assign full = (fill == FW'(DEPTH));

    // in_ok: the upstream held a grant for this cycle.
    if (IN_RL == 0) begin : g_in_rl0
        assign in_ok = in_ready;
    end else begin : g_in_rl
        logic [IN_RL-1:0] hist;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) hist <= '0;
            else          hist <= IN_RL'({hist, in_ready});
        end
        assign in_ok = hist[IN_RL-1];
    end

    // With IN_RL=0 a beat only counts as presented while in_ready is high;
    // holding in_valid under backpressure is normal handshaking.
    assign bad_in  = in_valid && ((IN_RL == 0) ? (in_ready && full)
                                               : (!in_ok || full));
    assign bad_out = out_valid && !out_slot;
    assign wr_en   = in_valid && in_ok && !full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                protocol_err <= 1'b0;
        else if (bad_in || bad_out)  protocol_err <= 1'b1;
    end
`else
    // With IN_RL>0 the upstream only drives beats it was granted.
    assign wr_en = in_valid && ((IN_RL > 0) || in_ready);
`endif

    assign fill_next = fill + FW'(wr_en) - FW'(pop);

    // ---------------- pointers, fill, credit ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            in_ready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            fill     <= fill_next;
            // Leave room for the IN_RL beats that may already be granted.
            in_ready <= (fill_next <= FW'(DEPTH - 1 - IN_RL));
        end
    end

    // Storage is not reset: contents are only read while marked valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_data, in_startofpacket, in_endofpacket};
    end

    // Show-ahead head; no fall-through, so a write is visible next cycle.
    assign head              = mem[rd_ptr];
    assign out_data          = head[W-1:2];
    assign out_startofpacket = head[1];
    assign out_endofpacket   = head[0];
    assign fill_level        = fill;

endmodule

// File: tb/tb_lcd_st_timing_adapter_rl.sv
// Bench for lcd_st_timing_adapter_rl. Three instances cover the
// configurations of interest:
//   0: IN_RL=1, OUT_RL=0, DEPTH=4
//   1: IN_RL=0, OUT_RL=2, DEPTH=4
//   2: IN_RL=1, OUT_RL=1, DEPTH=3 (non-power-of-two)
// Expected beats are queued when the upstream model hands a beat over and
// compared in order when the DUT delivers one.
module tb_lcd_st_timing_adapter_rl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [2:0]       in_ready, in_valid, in_sop, in_eop;
    logic [2:0]       out_ready, out_valid, out_sop, out_eop;
    logic [2:0][7:0]  in_data, out_data;
    logic [2:0]       fill_a, fill_b;
    logic [1:0]       fill_c;
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
    logic [2:0]       perr;
`endif

    lcd_st_timing_adapter_rl #(.DATA_W(8), .IN_RL(1), .OUT_RL(0), .DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready[0]), .in_valid(in_valid[0]),
        .in_data(in_data[0]), .in_startofpacket(in_sop[0]), .in_endofpacket(in_eop[0]),
        .out_ready(out_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_startofpacket(out_sop[0]), .out_endofpacket(out_eop[0]), .fill_level(fill_a)
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
        , .protocol_err(perr[0])
`endif
    );

    lcd_st_timing_adapter_rl #(.DATA_W(8), .IN_RL(0), .OUT_RL(2), .DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready[1]), .in_valid(in_valid[1]),
        .in_data(in_data[1]), .in_startofpacket(in_sop[1]), .in_endofpacket(in_eop[1]),
        .out_ready(out_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_startofpacket(out_sop[1]), .out_endofpacket(out_eop[1]), .fill_level(fill_b)
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
        , .protocol_err(perr[1])
`endif
    );

    lcd_st_timing_adapter_rl #(.DATA_W(8), .IN_RL(1), .OUT_RL(1), .DEPTH(3)) u_c (
        .clk(clk), .reset_n(reset_n), .in_ready(in_ready[2]), .in_valid(in_valid[2]),
        .in_data(in_data[2]), .in_startofpacket(in_sop[2]), .in_endofpacket(in_eop[2]),
        .out_ready(out_ready[2]), .out_valid(out_valid[2]), .out_data(out_data[2]),
        .out_startofpacket(out_sop[2]), .out_endofpacket(out_eop[2]), .fill_level(fill_c)
`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
        , .protocol_err(perr[2])
`endif
    );

    int checks = 0;
    int errors = 0;

    int irl [3];
    int orl [3];
    int src_left [3];
    int src_pct [3];
    int seq [3];
    int pkt [3];
    int rmode [3];      // 0: ready=1, 1: ready=0, 2: toggle, 3: random
    int delivered [3];
    bit [4:0] rh [3];   // in_ready seen per cycle, bit0 = current cycle
    bit [4:0] orh [3];  // out_ready driven per cycle, bit0 = last cycle
    int cyc, first_a, last_a, maxfill_a;
    bit bad_pending, bad_sent;

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int k, input logic [9:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int k, output logic [9:0] v);
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    // One clock cycle: sample outputs at the falling edge, then drive inputs.
    task automatic tick();
        logic [9:0] exp_v;
        @(negedge clk);
        cyc++;
        if (int'(fill_a) > maxfill_a) maxfill_a = int'(fill_a);
        chk("a_in_ready_vs_fill", in_ready[0], (fill_a <= 3'd2));
        for (int k = 0; k < 3; k++) begin
            rh[k] = {rh[k][3:0], in_ready[k]};
            if (orl[k] > 0 && out_valid[k])
                chk("out_valid_ready_history", orh[k][orl[k]-1], 1);
            case (rmode[k])
                0:       out_ready[k] = 1'b1;
                1:       out_ready[k] = 1'b0;
                2:       out_ready[k] = ~out_ready[k];
                default: out_ready[k] = 1'($urandom_range(0, 1));
            endcase
            orh[k] = {orh[k][3:0], out_ready[k]};
            if (out_valid[k] && (orl[k] > 0 || out_ready[k])) begin
                if (sb_size(k) == 0) begin
                    chk("beat_expected", (sb_size(k) > 0), 1);
                end else begin
                    sb_pop(k, exp_v);
                    chk("beat_payload", {out_data[k], out_sop[k], out_eop[k]}, exp_v);
                end
                delivered[k]++;
                if (k == 0) begin
                    if (first_a < 0) first_a = cyc;
                    last_a = cyc;
                end
            end
            in_valid[k] = 1'b0;
            in_sop[k]   = 1'b0;
            in_eop[k]   = 1'b0;
            if (k == 0 && bad_pending && !rh[0][1]) begin
                // Beat presented without a grant one cycle earlier.
                in_valid[0] = 1'b1;
                in_data[0]  = 8'hAA;
                bad_pending = 1'b0;
                bad_sent    = 1'b1;
            end else if (src_left[k] > 0 && (irl[k] == 0 || rh[k][irl[k]]) &&
                         $urandom_range(0, 99) < src_pct[k]) begin
                in_valid[k] = 1'b1;
                in_data[k]  = 8'(seq[k]);
                in_sop[k]   = ((seq[k] % pkt[k]) == 0);
                in_eop[k]   = ((seq[k] % pkt[k]) == pkt[k] - 1);
                if (irl[k] > 0 || in_ready[k]) begin
                    sb_push(k, {in_data[k], in_sop[k], in_eop[k]});
                    seq[k]++;
                    src_left[k]--;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_left[0] + src_left[1] + src_left[2] +
                sb_size(0) + sb_size(1) + sb_size(2)) > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", (n < budget), 1);
        run(4);
    endtask

    task automatic enter_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        in_sop    = '0;
        in_eop    = '0;
        in_data   = '0;
        out_ready = '0;
        q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < 3; k++) begin
            rh[k] = '0; orh[k] = '0; src_left[k] = 0; rmode[k] = 0;
        end
        #1;
        chk("rst_in_ready", in_ready, 3'b000);
        chk("rst_out_valid", out_valid, 3'b000);
        chk("rst_fill_a", fill_a, 0);
        chk("rst_fill_b", fill_b, 0);
        chk("rst_fill_c", fill_c, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", in_ready, 3'b111);
    endtask

    initial begin
        irl = '{1, 0, 1};
        orl = '{0, 2, 1};
        for (int k = 0; k < 3; k++) begin
            src_pct[k] = 100; seq[k] = 0; pkt[k] = 16; delivered[k] = 0;
        end
        cyc = 0; first_a = -1; last_a = -1; maxfill_a = 0;
        bad_pending = 1'b0; bad_sent = 1'b0;
        enter_reset();

        // 1: 16 beats through instance 0 with out_ready held high.
        seq[0] = 0; src_left[0] = 16; delivered[0] = 0; first_a = -1;
        drain(200);
        chk("t1_count", delivered[0], 16);
        chk("t1_back_to_back", last_a - first_a, 15);

        // 2: 10-cycle downstream stall mid-stream.
        src_left[0] = 16; delivered[0] = 0; maxfill_a = 0;
        run(4);
        rmode[0] = 1;
        run(10);
        rmode[0] = 0;
        drain(200);
        chk("t2_max_fill", maxfill_a, 4);
        chk("t2_count", delivered[0], 16);

        // 3: output latency 2 with toggling out_ready.
        pkt[1] = 4; src_left[1] = 8; delivered[1] = 0; rmode[1] = 2;
        drain(200);
        chk("t3_count", delivered[1], 8);
        rmode[1] = 0;

        // 4: reset with three beats buffered.
        rmode[0] = 1; src_left[0] = 3;
        for (int i = 0; i < 30 && fill_a != 3'd3; i++) tick();
        chk("t4_fill_before_reset", fill_a, 3);
        #2;
        enter_reset();

        // 5: depth-3 instance, random traffic; 50 pops wrap rd_ptr 16 times.
        pkt[2] = 5; src_left[2] = 50; src_pct[2] = 60; rmode[2] = 3; delivered[2] = 0;
        drain(3000);
        chk("t5_count", delivered[2], 50);
        rmode[2] = 0;

`ifdef LCD_ST_TA_PROTOCOL_CHECK_EN
        // 6: ungranted beat 0xAA must be flagged and dropped.
        seq[0] = 0; pkt[0] = 8; src_left[0] = 8; rmode[0] = 1; bad_pending = 1'b1;
        for (int i = 0; i < 40 && !bad_sent; i++) tick();
        chk("t6_bad_beat_sent", bad_sent, 1);
        chk("t6_err_clear_before", perr[0], 0);
        tick();
        chk("t6_err_set", perr[0], 1);
        rmode[0] = 0;
        drain(200);
        chk("t6_err_sticky", perr[0], 1);
        chk("t6_err_others", perr[2:1], 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_st_timing_adapter_rl.md
Name: lcd_st_timing_adapter_rl

Overview:
Parametrised Avalon-ST timing adapter. It bridges an upstream and a downstream that use arbitrary, independent ready latencies. Data width is configurable, and SOP/EOP travel with the data. An internal show-ahead buffer with credit-style ready generation absorbs in-flight beats, so no beat is dropped and no beat is duplicated. It sits between stream producers (pixel formatters) and consumers (FIFOs, LCD drivers) in the display datapath.

Parameters:
DATA_W, 8, data bits per beat.
IN_RL, 1, ready latency on the input side (0..4). The upstream may present a beat at cycle t only if in_ready was 1 at cycle t-IN_RL.
OUT_RL, 0, ready latency on the output side (0..4). The adapter may assert out_valid at t only if out_ready was 1 at t-OUT_RL.
DEPTH, 4, buffer entries. DEPTH < IN_RL+1 is an elaboration error. DEPTH >= IN_RL+2 is required for sustained 1 beat/cycle.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_ready  output  1  upstream grant, registered.
in_valid  input  1  upstream beat valid.
in_data  input  DATA_W  upstream data.
in_startofpacket  input  1  upstream SOP.
in_endofpacket  input  1  upstream EOP.
out_ready  input  1  downstream ready.
out_valid  output  1  downstream beat valid.
out_data  output  DATA_W  downstream data.
out_startofpacket  output  1  downstream SOP.
out_endofpacket  output  1  downstream EOP.
fill_level  output  clog2(DEPTH+1)  current buffer occupancy, registered.

Behaviour:
- Reset (async assert, sync release): buffer empty, fill_level=0, in_ready=0, out_valid=0, all ready-history bits 0. out_data, SOP and EOP are don't-care while out_valid=0. Reset mid-packet discards all buffered beats, with no flush.
- Payload word = {data, sop, eop}, width DATA_W+2. It is stored in a circular buffer with wr_ptr and rd_ptr (mod DEPTH) and a fill counter.
- Write:
  - IN_RL=0: accept when in_valid && in_ready.
  - IN_RL>0: accept whenever in_valid=1. The upstream guarantees legality.
- in_ready register: next value = (fill_next <= DEPTH-1-IN_RL). This guarantees room for every beat already granted.
- Output head is show-ahead: out_data/SOP/EOP are driven combinationally from the entry at rd_ptr.
- A beat written at cycle t is visible at the head at t+1. There is no fall-through, so minimum latency is 1 cycle.
- Output with OUT_RL=0:
  - out_valid = !empty.
  - Pop when out_valid && out_ready.
- Output with OUT_RL>0:
  - out_ready is shifted through an OUT_RL-deep history register.
  - out_valid = hist[OUT_RL-1] && !empty.
  - Pop whenever out_valid=1; the downstream must take the beat.
- Simultaneous write and pop: fill is unchanged and both pointers advance.
- Write to a full buffer cannot occur under legal upstream behaviour.
- Pop from an empty buffer never occurs.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- Beat order and SOP/EOP bits are preserved exactly. The adapter never creates, merges or splits packets.
- When IN_RL=1, OUT_RL=0 and DEPTH>=3, the adapter is a drop-in superset of the fixed RL1->RL0 adapter, with one extra cycle of latency.

Optional Feature:
Macro LCD_ST_TA_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port protocol_err (1 bit, reset 0, sticky until reset).
  - It is set the cycle after in_valid=1 when in_ready was 0 at t-IN_RL (IN_RL>0), or when in_valid=1 with the buffer full (any IN_RL).
  - The offending beat is dropped and not written.
  - It is also set if out_valid is asserted without the required out_ready history. This is an internal sanity check.
- Undefined: the port and its checking logic are absent. Illegal upstream beats are undefined behaviour.

Test Plan:
1. IN_RL=1, OUT_RL=0, DEPTH=4; out_ready=1 held; upstream sends 0x00..0x0F obeying latency, SOP on 0x00, EOP on 0x0F -> out_valid sustains 1/cycle after 2 cycles of latency; sequence and SOP/EOP are identical.
2. Same configuration; out_ready=0 for 10 cycles mid-stream -> fill_level rises to 4 max, in_ready drops when fill>=3, no loss; after release, data resumes in order.
3. IN_RL=0, OUT_RL=2, DEPTH=4; out_ready toggles 1,0,1,0 -> out_valid appears only 2 cycles after each out_ready=1; each valid pops one beat; 8 beats delivered in order.
4. Reset asserted with fill_level=3 -> in_ready=0, out_valid=0 and fill_level=0 immediately; in_ready=1 on the first clock after release.
5. DEPTH=3 (non-power-of-two), IN_RL=1, 50 random beats with random out_ready -> the scoreboard matches, and pointer wrap is exercised ≥10 times.
6. With LCD_ST_TA_PROTOCOL_CHECK_EN, IN_RL=1: drive in_valid=1 one cycle after in_ready=0 -> protocol_err=1 next cycle and stays set; beat 0xAA is absent from the output.
